// File: rtl/tone_period_meter.sv
// Measures period and high time of an asynchronous square wave in clk cycles; results strobe one cycle after the rise cycle (rise is 3 edges after the input edge).
// No backpressure: period_valid is a single-cycle strobe the consumer must take when it appears.
module tone_period_meter #(
    parameter int WIDTH          = 24,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             square_wave_in,
    input  logic             measure_enable,
    output logic [WIDTH-1:0] period_out,
    output logic [WIDTH-1:0] high_time_out,
    output logic             period_valid,
    output logic             no_tone
);

    typedef enum logic {IDLE, MEASURE} state_t;

    localparam logic [WIDTH-1:0] TIMEOUT = WIDTH'(TIMEOUT_CYCLES);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    state_t           state_q, state_d;
    logic             s1_q, s2_q, s3_q;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] high_q, high_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] hightime_q, hightime_d;
    logic             valid_q, valid_d;
    logic             no_tone_q, no_tone_d;
    logic             rise;

    assign rise = s2_q & ~s3_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            count_q    <= '0;
            high_q     <= '0;
            period_q   <= '0;
            hightime_q <= '0;
            valid_q    <= 1'b0;
            no_tone_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            s1_q       <= square_wave_in;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            count_q    <= count_d;
            high_q     <= high_d;
            period_q   <= period_d;
            hightime_q <= hightime_d;
            valid_q    <= valid_d;
            no_tone_q  <= no_tone_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        high_d     = high_q;
        period_d   = period_q;
        hightime_d = hightime_q;
        valid_d    = 1'b0;
        no_tone_d  = no_tone_q;

        if (!measure_enable) begin
            // Results hold while disabled; only the running counters are dropped.
            state_d = IDLE;
            count_d = '0;
            high_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    count_d = '0;
                    high_d  = '0;
                    if (rise) begin
                        state_d = MEASURE;
                        count_d = ONE;
                        high_d  = ONE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_d   = count_q;
                        hightime_d = high_q;
                        valid_d    = 1'b1;
                        no_tone_d  = 1'b0;
                        count_d    = ONE;
                        high_d     = ONE;
                    end else if (count_q == TIMEOUT) begin
                        // A rise in this same cycle would have won above, so a period of exactly TIMEOUT is kept.
                        state_d    = IDLE;
                        no_tone_d  = 1'b1;
                        period_d   = '0;
                        hightime_d = '0;
                        count_d    = '0;
                        high_d     = '0;
                    end else begin
                        count_d = count_q + ONE;
                        high_d  = high_q + WIDTH'(s2_q);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign period_out    = period_q;
    assign high_time_out = hightime_q;
    assign period_valid  = valid_q;
    assign no_tone       = no_tone_q;

endmodule

// File: tb/tb_tone_period_meter.sv
// Directed bench for tone_period_meter with a 1000-cycle timeout.
module tb_tone_period_meter;

    localparam int WIDTH = 24;
    localparam int TMO   = 1000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             square_wave_in = 1'b0;
    logic             measure_enable = 1'b1;
    logic [WIDTH-1:0] period_out;
    logic [WIDTH-1:0] high_time_out;
    logic             period_valid;
    logic             no_tone;

    tone_period_meter #(.WIDTH(WIDTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk            (clk),
        .rst            (rst),
        .square_wave_in (square_wave_in),
        .measure_enable (measure_enable),
        .period_out     (period_out),
        .high_time_out  (high_time_out),
        .period_valid   (period_valid),
        .no_tone        (no_tone)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int errors = 0;
    int cyc    = 0;
    int phase  = 0;
    int sp[$];
    int sh[$];
    int last_strobe_cyc = -1;
    int notone_rise_cyc = -1;
    logic prev_no_tone = 1'b1;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst && period_valid) begin
            sp.push_back(int'(period_out));
            sh.push_back(int'(high_time_out));
            last_strobe_cyc = cyc;
        end
        if (no_tone && !prev_no_tone) notone_rise_cyc = cyc;
        prev_no_tone = no_tone;
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wave(input int per, input int hi, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            square_wave_in = (phase < hi);
            phase++;
            if (phase >= per) phase = 0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        square_wave_in = 1'b0;
        measure_enable = 1'b1;
        phase = 0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        sp.delete();
        sh.delete();
        notone_rise_cyc = -1;
        repeat (4) @(posedge clk);
    endtask

    typedef struct {
        int per;
        int hi;
        int exp_n;
        int exp_p;
        int exp_h;
        int exp_nt;
    } vec_t;

    vec_t vecs[7];

    initial begin
        // 3*per+10 cycles from phase 0 give rises at 0, per, 2per, 3per -> three strobes.
        vecs[0] = '{per: 100,  hi: 50,  exp_n: 3, exp_p: 100,  exp_h: 50,  exp_nt: 0};
        vecs[1] = '{per: 400,  hi: 100, exp_n: 3, exp_p: 400,  exp_h: 100, exp_nt: 0};
        vecs[2] = '{per: 60,   hi: 30,  exp_n: 3, exp_p: 60,   exp_h: 30,  exp_nt: 0};
        vecs[3] = '{per: 7,    hi: 3,   exp_n: 3, exp_p: 7,    exp_h: 3,   exp_nt: 0};
        vecs[4] = '{per: 250,  hi: 249, exp_n: 3, exp_p: 250,  exp_h: 249, exp_nt: 0};
        vecs[5] = '{per: 1000, hi: 1,   exp_n: 3, exp_p: 1000, exp_h: 1,   exp_nt: 0};
        vecs[6] = '{per: 1001, hi: 500, exp_n: 0, exp_p: 0,    exp_h: 0,   exp_nt: 1};

        #12;
        check("reset period_out", int'(period_out), 0);
        check("reset high_time_out", int'(high_time_out), 0);
        check("reset period_valid", int'(period_valid), 0);
        check("reset no_tone", int'(no_tone), 1);

        for (int v = 0; v < 7; v++) begin
            do_reset();
            wave(vecs[v].per, vecs[v].hi, 3 * vecs[v].per + 10);
            check($sformatf("v%0d strobes", v), sp.size(), vecs[v].exp_n);
            check($sformatf("v%0d period_out", v), int'(period_out), vecs[v].exp_p);
            check($sformatf("v%0d high_time_out", v), int'(high_time_out), vecs[v].exp_h);
            check($sformatf("v%0d no_tone", v), int'(no_tone), vecs[v].exp_nt);
            if (sp.size() > 0) begin
                check($sformatf("v%0d first period", v), sp[0], vecs[v].exp_p);
                check($sformatf("v%0d first high", v), sh[0], vecs[v].exp_h);
            end
        end

        // Period switch mid-cycle: last old rise at 800, first new rise at 1000.
        do_reset();
        wave(400, 100, 1000);
        phase = 0;
        wave(60, 30, 190);
        check("switch strobes", sp.size(), 6);
        if (sp.size() >= 4) begin
            check("switch old period", sp[1], 400);
            check("switch transitional period", sp[2], 200);
            check("switch transitional high", sh[2], 100);
            check("switch new period", sp[3], 60);
            check("switch new high", sh[3], 30);
        end

        // Tone stops after valid measurements.
        do_reset();
        wave(100, 50, 310);
        wave(100, 0, 1100);
        check("timeout delay", notone_rise_cyc - last_strobe_cyc, TMO);
        check("timeout strobes", sp.size(), 3);
        check("timeout no_tone", int'(no_tone), 1);
        check("timeout period_out", int'(period_out), 0);
        check("timeout high_time_out", int'(high_time_out), 0);

        // Reset 37 cycles after a rise, released while the input is low.
        do_reset();
        wave(100, 50, 237);
        rst = 1'b1;
        #2;
        check("midrst period_out", int'(period_out), 0);
        check("midrst high_time_out", int'(high_time_out), 0);
        check("midrst period_valid", int'(period_valid), 0);
        check("midrst no_tone", int'(no_tone), 1);
        wave(100, 50, 23);
        rst = 1'b0;
        sp.delete();
        sh.delete();
        wave(100, 50, 100);
        check("postrst no strobe after one rise", sp.size(), 0);
        wave(100, 50, 130);
        check("postrst strobes", sp.size(), 1);
        check("postrst period_out", int'(period_out), 100);
        check("postrst high_time_out", int'(high_time_out), 50);

        // Disable holds results; re-enable needs two rises.
        do_reset();
        wave(100, 50, 250);
        measure_enable = 1'b0;
        phase = 0;
        wave(60, 20, 310);
        check("disabled strobes", sp.size(), 2);
        check("disabled period_out", int'(period_out), 100);
        check("disabled high_time_out", int'(high_time_out), 50);
        check("disabled no_tone", int'(no_tone), 0);
        measure_enable = 1'b1;
        wave(60, 20, 60);
        check("reenable one rise no strobe", sp.size(), 2);
        wave(60, 20, 80);
        check("reenable strobes", sp.size(), 3);
        check("reenable period_out", int'(period_out), 60);
        check("reenable high_time_out", int'(high_time_out), 20);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tone_period_meter.md
Name: tone_period_meter

Overview:
- Receive-side counterpart of the tone generator: takes an incoming square wave (piezo drive or external tone) and measures its period and high time in clk cycles.
- Raises a one-cycle valid strobe per completed period and flags when no tone is present.
- Sits beside tone_generator for loopback self-check and feeds period values to a display/UART path.

Parameters:
- WIDTH, 24, width of period/high-time counters and outputs; must satisfy 2^WIDTH > TIMEOUT_CYCLES.
- TIMEOUT_CYCLES, 2000000, longest measurable period in clk cycles; no rising edge within this many cycles means no tone.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- square_wave_in  input  1  tone input, asynchronous to clk.
- measure_enable  input  1  1 = measure; 0 = force IDLE and hold outputs.
- period_out  output  WIDTH  clk cycles between the last two rising edges.
- high_time_out  output  WIDTH  clk cycles the input was high within that period.
- period_valid  output  1  one-cycle strobe; period_out and high_time_out updated this cycle.
- no_tone  output  1  1 = no valid period measured, or timed out.

Behaviour:
- Reset is asynchronous: state=IDLE, sync flops=0, count=0, high_cnt=0, period_out=0, high_time_out=0, period_valid=0, no_tone=1.
- Input sync: two flops s1->s2, plus delay flop s3; rise = s2 & ~s3. The rise cycle is 3 clk edges after the input edge.
- States: IDLE and MEASURE.
- IDLE with measure_enable=1 and rise: count<=1, high_cnt<=1, go to MEASURE. The first edge yields no measurement.
- MEASURE, rise cycle:
  - period_out<=count, high_time_out<=high_cnt, period_valid<=1, no_tone<=0.
  - count<=1, high_cnt<=1.
- MEASURE, non-rise cycle: count<=count+1, high_cnt<=high_cnt+s2.
- Result: rises at cycles N and N+P give period_out=P. high_time_out counts cycles with s2=1 in [N, N+P-1].
- period_valid is registered and is high exactly one cycle, the cycle after the rise. It is 0 in all other cycles.
- Timeout: in MEASURE with count==TIMEOUT_CYCLES and no rise, next state is IDLE, no_tone<=1, period_out<=0, high_time_out<=0, no strobe.
- Timeout and rise in the same cycle: rise wins. A period of exactly TIMEOUT_CYCLES is valid; TIMEOUT_CYCLES+1 times out.
- Count never exceeds TIMEOUT_CYCLES, so no wrap-around is possible.
- measure_enable=0:
  - Next state is IDLE; count and high_cnt are cleared.
  - period_out, high_time_out and no_tone hold; no strobe.
  - Sync flops keep running.
  - Re-enable needs two fresh rising edges before the next strobe.
- Constant-high or constant-low input: no rises, so timeout behaviour applies.
- Duty near 100%: high_time_out = P-1 is legal.
- rst asserted mid-measurement: all state and outputs return to reset values immediately. No strobe is emitted for the interrupted period.

Test Plan:
- Input period 100 cycles, high 50, enable=1 -> first strobe after the second rise: period_out=100, high_time_out=50, no_tone 1->0. Further strobes follow every 100 cycles with the same values.
- Input period 400, high 100 -> period_out=400, high_time_out=100. Switch to period 60, high 30 -> the first strobe after the switch reports the transitional period, and the next strobe reports 60/30.
- Input stops toggling after a valid measurement -> exactly TIMEOUT_CYCLES+1 cycles after the last rise cycle, no_tone=1, period_out=0, high_time_out=0, no strobe. Use TIMEOUT_CYCLES=1000 in the bench.
- TIMEOUT_CYCLES=1000, input period exactly 1000 -> strobe with period_out=1000. Period 1001 -> timeout, no_tone=1, no strobe.
- Assert rst 37 cycles into a period -> all outputs at reset values in the same cycle. After release, the first strobe comes only after two rises.
- measure_enable=0 mid-stream -> outputs hold their last values (e.g. 100/50), no strobes. Re-enable -> the first strobe comes after the second rise.
